// File: rtl/ifm_streamer_if.sv
// IFM streamer bus: SRAM read port plus the pixel strobe stream into the row buffers.
// master = streamer side, slave = SRAM/buffer side.
interface ifm_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [DATA_W-1:0] mem_rdata;
  logic                     ifm_ready;
  logic signed [DATA_W-1:0] ifm_input;
  logic                     ifm_read;
  logic [1:0]               ifm_row;
  logic                     win_valid;
  logic                     ifm_last;

  modport master (
    output mem_rd_en, mem_addr, ifm_input, ifm_read, ifm_row, win_valid, ifm_last,
    input  mem_rdata, ifm_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, ifm_input, ifm_read, ifm_row, win_valid, ifm_last,
    output mem_rdata, ifm_ready
  );
endinterface

// File: rtl/ifm_streamer.sv
// Streams IFM pixels from SRAM into the row buffers in KxK sliding-window order,
// with a one-entry hold register absorbing consumer back-pressure.
module ifm_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  ifm_streamer_if.master    bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H - K + 1 > 1) ? $clog2(IMG_H - K + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        kr_q, kr_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_kr_q, pend_kr_d;
  logic              pend_win_q, pend_win_d;
  logic              pend_last_q, pend_last_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [1:0]        hold_kr_q, hold_kr_d;
  logic              hold_win_q, hold_win_d;
  logic              hold_last_q, hold_last_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic              issue;
  logic              last_issue;
  logic              read;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_kr;
  logic              sel_win;
  logic              sel_last;

  // A new read may only go out when the previous pixel cannot end up needing the hold slot.
  always_comb begin
    issue      = (state_q == S_RUN) && bus.ifm_ready && !hold_q;
    last_issue = (kr_q == 2'(K - 1)) && (c_q == CW'(IMG_W - 1)) && (r_q == RW'(IMG_H - K));
    row_off    = ADDR_W'(r_q) + ADDR_W'(kr_q);
    addr       = base_q + row_off * ADDR_W'(IMG_W) + ADDR_W'(c_q);
    read       = (pend_q || hold_q) && bus.ifm_ready;
    sel_data   = hold_q ? hold_data_q : bus.mem_rdata;
    sel_kr     = hold_q ? hold_kr_q   : pend_kr_q;
    sel_win    = hold_q ? hold_win_q  : pend_win_q;
    sel_last   = hold_q ? hold_last_q : pend_last_q;
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = issue ? addr : '0;
  assign bus.ifm_read  = read;
  assign bus.ifm_input = read ? sel_data : out_q;
  assign bus.ifm_row   = read ? sel_kr : 2'd0;
  assign bus.win_valid = read && sel_win;
  assign bus.ifm_last  = read && sel_last;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    kr_d        = kr_q;
    c_d         = c_q;
    r_d         = r_q;
    pend_d      = issue;
    pend_kr_d   = kr_q;
    pend_win_d  = (kr_q == 2'(K - 1)) && (c_q >= CW'(K - 1));
    pend_last_d = last_issue;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    hold_kr_d   = hold_kr_q;
    hold_win_d  = hold_win_q;
    hold_last_d = hold_last_q;
    out_d       = read ? sel_data : out_q;

    if (pend_q && !bus.ifm_ready) begin
      hold_d      = 1'b1;
      hold_data_d = bus.mem_rdata;
      hold_kr_d   = pend_kr_q;
      hold_win_d  = pend_win_q;
      hold_last_d = pend_last_q;
    end else if (hold_q && bus.ifm_ready) begin
      hold_d = 1'b0;
    end

    // kr runs fastest, then column, then output row.
    if (issue) begin
      if (kr_q == 2'(K - 1)) begin
        kr_d = '0;
        if (c_q == CW'(IMG_W - 1)) begin
          c_d = '0;
          r_d = (r_q == RW'(IMG_H - K)) ? '0 : r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end else begin
        kr_d = kr_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        base_d  = base_addr;
        kr_d    = '0;
        c_d     = '0;
        r_d     = '0;
      end
      S_RUN:   if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (read && sel_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      kr_q        <= '0;
      c_q         <= '0;
      r_q         <= '0;
      pend_q      <= 1'b0;
      pend_kr_q   <= '0;
      pend_win_q  <= 1'b0;
      pend_last_q <= 1'b0;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
      hold_kr_q   <= '0;
      hold_win_q  <= 1'b0;
      hold_last_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      kr_q        <= kr_d;
      c_q         <= c_d;
      r_q         <= r_d;
      pend_q      <= pend_d;
      pend_kr_q   <= pend_kr_d;
      pend_win_q  <= pend_win_d;
      pend_last_q <= pend_last_d;
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
      hold_kr_q   <= hold_kr_d;
      hold_win_q  <= hold_win_d;
      hold_last_q <= hold_last_d;
      out_q       <= out_d;
    end
  end

endmodule
